// File: rtl/manchester_rx_ctrl.sv
// Receive-side Manchester frame controller: hunts the sync word, packs 16 chips per word for the
// external decoder, validates chip pairs and emits length-prefixed frames as a valid/ready stream.
module manchester_rx_ctrl #(
    parameter logic [15:0] SYNC_WORD = 16'hFF00,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        chip_in,
    input  logic        chip_valid,
    output logic [15:0] dec_din,
    input  logic [7:0]  dec_dout,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  frame_len,
    output logic        frame_done,
    output logic        code_err,
    output logic        ovf_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StHunt,
        StLen,
        StPayload
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [15:0]       r_shreg;
    logic [15:0]       w_shreg_d;
    logic [3:0]        r_chip_cnt;
    logic [3:0]        w_chip_cnt_d;
    logic [15:0]       r_word_q;
    logic [15:0]       w_word_q_d;
    logic              r_word_rdy;
    logic              w_word_rdy_d;
    logic [CntW-1:0]   r_idle_cnt;
    logic [CntW-1:0]   w_idle_cnt_d;
    logic [7:0]        r_remaining;
    logic [7:0]        w_remaining_d;
    logic [7:0]        r_frame_len;
    logic [7:0]        w_frame_len_d;
    logic [7:0]        r_byte_out;
    logic [7:0]        w_byte_out_d;
    logic              r_byte_valid;
    logic              w_byte_valid_d;
    logic              r_frame_done;
    logic              w_frame_done_d;
    logic              r_code_err;
    logic              w_code_err_d;
    logic              r_ovf_err;
    logic              w_ovf_err_d;
    logic              r_timeout_err;
    logic              w_timeout_err_d;

    logic [15:0]       w_shreg_nxt;
    logic              w_pair_err;
    logic              w_to_hunt;

    assign w_shreg_nxt = {r_shreg[14:0], chip_in};

    // A valid Manchester pair always has differing chips; 00 or 11 anywhere rejects the word.
    always_comb begin
        w_pair_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r_word_q[2*i+1] == r_word_q[2*i]) begin
                w_pair_err = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_shreg_d       = r_shreg;
        w_chip_cnt_d    = r_chip_cnt;
        w_word_q_d      = r_word_q;
        w_word_rdy_d    = 1'b0;
        w_idle_cnt_d    = r_idle_cnt;
        w_remaining_d   = r_remaining;
        w_frame_len_d   = r_frame_len;
        w_byte_out_d    = r_byte_out;
        w_byte_valid_d  = r_byte_valid & ~byte_ready;
        w_frame_done_d  = 1'b0;
        w_code_err_d    = 1'b0;
        w_ovf_err_d     = 1'b0;
        w_timeout_err_d = 1'b0;
        w_to_hunt       = 1'b0;

        if (!enable) begin
            w_state_d      = StHunt;
            w_shreg_d      = '0;
            w_chip_cnt_d   = '0;
            w_idle_cnt_d   = '0;
            w_remaining_d  = '0;
            w_byte_valid_d = 1'b0;
        end else begin
            unique case (r_state)
                StHunt: begin
                    if (chip_valid) begin
                        w_shreg_d = w_shreg_nxt;
                        if (w_shreg_nxt == SYNC_WORD) begin
                            w_state_d    = StLen;
                            w_chip_cnt_d = '0;
                            w_idle_cnt_d = '0;
                        end
                    end
                end

                default: begin
                    if (chip_valid) begin
                        w_shreg_d    = w_shreg_nxt;
                        w_idle_cnt_d = '0;
                        w_chip_cnt_d = r_chip_cnt + 4'd1;
                        if (r_chip_cnt == 4'd15) begin
                            w_word_q_d   = w_shreg_nxt;
                            w_word_rdy_d = 1'b1;
                        end
                    end else if (r_idle_cnt == CntW'(TIMEOUT - 1)) begin
                        w_timeout_err_d = 1'b1;
                        w_to_hunt       = 1'b1;
                    end else begin
                        w_idle_cnt_d = r_idle_cnt + 1'b1;
                    end

                    if (r_word_rdy) begin
                        if (w_pair_err) begin
                            w_code_err_d = 1'b1;
                            w_to_hunt    = 1'b1;
                        end else if (r_state == StLen) begin
                            // The length byte only sets up the frame; it never reaches byte_out.
                            w_frame_len_d = dec_dout;
                            w_remaining_d = dec_dout;
                            if (dec_dout == 8'd0) begin
                                w_frame_done_d = 1'b1;
                                w_to_hunt      = 1'b1;
                            end else begin
                                w_state_d = StPayload;
                            end
                        end else if (r_byte_valid && !byte_ready) begin
                            w_ovf_err_d = 1'b1;
                            w_to_hunt   = 1'b1;
                        end else begin
                            w_byte_out_d   = dec_dout;
                            w_byte_valid_d = 1'b1;
                            w_remaining_d  = r_remaining - 8'd1;
                            if (r_remaining == 8'd1) begin
                                w_frame_done_d = 1'b1;
                                w_to_hunt      = 1'b1;
                            end
                        end
                    end

                    // Any exit restarts the sync search from an empty shift register.
                    if (w_to_hunt) begin
                        w_state_d     = StHunt;
                        w_shreg_d     = '0;
                        w_chip_cnt_d  = '0;
                        w_idle_cnt_d  = '0;
                        w_remaining_d = '0;
                        w_word_rdy_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StHunt;
            r_shreg       <= '0;
            r_chip_cnt    <= '0;
            r_word_q      <= '0;
            r_word_rdy    <= 1'b0;
            r_idle_cnt    <= '0;
            r_remaining   <= '0;
            r_frame_len   <= '0;
            r_byte_out    <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_code_err    <= 1'b0;
            r_ovf_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_shreg       <= w_shreg_d;
            r_chip_cnt    <= w_chip_cnt_d;
            r_word_q      <= w_word_q_d;
            r_word_rdy    <= w_word_rdy_d;
            r_idle_cnt    <= w_idle_cnt_d;
            r_remaining   <= w_remaining_d;
            r_frame_len   <= w_frame_len_d;
            r_byte_out    <= w_byte_out_d;
            r_byte_valid  <= w_byte_valid_d;
            r_frame_done  <= w_frame_done_d;
            r_code_err    <= w_code_err_d;
            r_ovf_err     <= w_ovf_err_d;
            r_timeout_err <= w_timeout_err_d;
        end
    end

    assign dec_din     = r_word_q;
    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;
    assign frame_len   = r_frame_len;
    assign frame_done  = r_frame_done;
    assign code_err    = r_code_err;
    assign ovf_err     = r_ovf_err;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != StHunt);

endmodule

// File: tb/tb_manchester_rx_ctrl.sv
// Self-checking bench for manchester_rx_ctrl with a behavioural Manchester decoder and a byte
// scoreboard that pops expected payload bytes on every accepted handshake.
module tb_manchester_rx_ctrl;

    localparam int unsigned TIMEOUT = 1024;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        chip_in;
    logic        chip_valid;
    logic [15:0] dec_din;
    logic [7:0]  dec_dout;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  frame_len;
    logic        frame_done;
    logic        code_err;
    logic        ovf_err;
    logic        timeout_err;
    logic        busy;

    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    manchester_rx_ctrl #(
        .SYNC_WORD (16'hFF00),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .chip_in     (chip_in),
        .chip_valid  (chip_valid),
        .dec_din     (dec_din),
        .dec_dout    (dec_dout),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_len   (frame_len),
        .frame_done  (frame_done),
        .code_err    (code_err),
        .ovf_err     (ovf_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: pair 01 -> 1, 10 -> 0; the low chip of each pair carries the bit.
    always_comb begin
        dec_dout = '0;
        for (int i = 0; i < 8; i++) begin
            dec_dout[i] = dec_din[2*i];
        end
    end

    // Scoreboard: every accepted byte must match the next expected payload byte.
    always @(negedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h want no byte", byte_out);
            end else begin
                exp_b = exp_q.pop_front();
                if (byte_out !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_byte: got %h want %h", byte_out, exp_b);
                end
            end
        end
    end

    function automatic logic [15:0] enc(input logic [7:0] b);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w[2*i+1 -: 2] = b[i] ? 2'b01 : 2'b10;
        end
        return w;
    endfunction

    task automatic send_chip(input logic c);
        @(posedge clk);
        #1;
        chip_in    = c;
        chip_valid = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            send_chip(w[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chip_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({byte_valid, frame_done, code_err, ovf_err, timeout_err, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {byte_valid, frame_done, code_err, ovf_err, timeout_err, busy});
        end
        n_tests++;
        if ({dec_din, byte_out, frame_len} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {dec_din, byte_out, frame_len});
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
    endtask

    task automatic test_frame();
        byte_ready = 1'b1;
        send_word(16'hFF00);
        send_word(16'hAAA6);
        step();
        n_tests++;
        if (frame_len !== 8'h00) begin
            n_fail++;
            $display("FAIL len_latency_early: got %h want %h", frame_len, 8'h00);
        end
        step();
        n_tests++;
        if (frame_len !== 8'h02 || busy !== 1'b1 || byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len_word: got len=%h busy=%b bv=%b want len=02 busy=1 bv=0",
                     frame_len, busy, byte_valid);
        end
        exp_q.push_back(8'hA5);
        send_word(16'h6699);
        step();
        step();
        n_tests++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hA5 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL first_byte: got bv=%b byte=%h fd=%b want bv=1 byte=a5 fd=0",
                     byte_valid, byte_out, frame_done);
        end
        exp_q.push_back(8'h3C);
        send_word(16'hA55A);
        step();
        n_tests++;
        if (byte_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_last: got bv=%b fd=%b want bv=0 fd=0", byte_valid, frame_done);
        end
        step();
        n_tests++;
        if (frame_done !== 1'b1 || byte_valid !== 1'b1 || byte_out !== 8'h3C || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL last_byte: got fd=%b bv=%b byte=%h busy=%b want fd=1 bv=1 byte=3c busy=0",
                     frame_done, byte_valid, byte_out, busy);
        end
        step();
        n_tests++;
        if (frame_done !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_end: got fd=%b pending=%0d want fd=0 pending=0",
                     frame_done, exp_q.size());
        end
    endtask

    task automatic test_code_err();
        byte_ready = 1'b1;
        send_word(16'hFF00);
        send_word(16'h6690);
        step();
        n_tests++;
        if (code_err !== 1'b0) begin
            n_fail++;
            $display("FAIL code_err_early: got %b want 0", code_err);
        end
        step();
        n_tests++;
        if (code_err !== 1'b1 || byte_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL code_err: got ce=%b bv=%b busy=%b want ce=1 bv=0 busy=0",
                     code_err, byte_valid, busy);
        end
        step();
        n_tests++;
        if (code_err !== 1'b0) begin
            n_fail++;
            $display("FAIL code_err_pulse: got %b want 0", code_err);
        end
        send_word(16'hFF00);
        send_word(enc(8'h01));
        exp_q.push_back(8'h5A);
        send_word(enc(8'h5A));
        step();
        step();
        n_tests++;
        if (frame_done !== 1'b1 || byte_out !== 8'h5A || frame_len !== 8'h01) begin
            n_fail++;
            $display("FAIL recover: got fd=%b byte=%h len=%h want fd=1 byte=5a len=01",
                     frame_done, byte_out, frame_len);
        end
        step();
    endtask

    task automatic test_len_zero();
        byte_ready = 1'b1;
        send_word(16'hFF00);
        send_word(16'hAAAA);
        step();
        step();
        n_tests++;
        if (frame_done !== 1'b1 || frame_len !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_zero: got fd=%b len=%h bv=%b busy=%b want fd=1 len=00 bv=0 busy=0",
                     frame_done, frame_len, byte_valid, busy);
        end
        step();
        n_tests++;
        if (byte_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL len_zero_after: got bv=%b fd=%b want 0 0", byte_valid, frame_done);
        end
    endtask

    task automatic test_overflow();
        byte_ready = 1'b0;
        send_word(16'hFF00);
        send_word(enc(8'h02));
        exp_q.push_back(8'hA5);
        send_word(enc(8'hA5));
        step();
        step();
        n_tests++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL ovf_hold: got bv=%b byte=%h want bv=1 byte=a5", byte_valid, byte_out);
        end
        send_word(enc(8'h3C));
        step();
        step();
        n_tests++;
        if (ovf_err !== 1'b1 || byte_out !== 8'hA5 || byte_valid !== 1'b1 || busy !== 1'b0 ||
            frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf: got ovf=%b byte=%h bv=%b busy=%b fd=%b want 1 a5 1 0 0",
                     ovf_err, byte_out, byte_valid, busy, frame_done);
        end
        byte_ready = 1'b1;
        step();
        n_tests++;
        if (ovf_err !== 1'b0 || byte_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_drain: got ovf=%b bv=%b pending=%0d want 0 0 0",
                     ovf_err, byte_valid, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        byte_ready = 1'b1;
        send_word(16'hFF00);
        send_word(enc(8'h01));
        step();
        repeat (TIMEOUT - 1) step();
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got to=%b busy=%b want to=0 busy=1", timeout_err, busy);
        end
        step();
        n_tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: got to=%b busy=%b want to=1 busy=0", timeout_err, busy);
        end
        step();
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_enable_drop();
        byte_ready = 1'b0;
        send_word(16'hFF00);
        send_word(enc(8'h02));
        send_word(enc(8'hA5));
        for (int i = 0; i < 5; i++) begin
            send_chip(i[0]);
        end
        @(posedge clk);
        #1;
        chip_valid = 1'b0;
        enable     = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || frame_len !== 8'h02 ||
            {code_err, ovf_err, timeout_err, frame_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL enable_drop: got bv=%b busy=%b len=%h errs=%b want 0 0 02 0000",
                     byte_valid, busy, frame_len, {code_err, ovf_err, timeout_err, frame_done});
        end
        enable = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        byte_ready = 1'b0;
        send_word(16'hFF00);
        send_word(enc(8'h02));
        send_word(enc(8'hA5));
        repeat (8) send_chip(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({byte_valid, busy, frame_done, code_err, ovf_err, timeout_err} !== 6'b0 ||
            {byte_out, frame_len, dec_din} !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got bv=%b busy=%b data=%h want all 0",
                     byte_valid, busy, {byte_out, frame_len, dec_din});
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        chip_valid = 1'b0;
        repeat (8) send_chip(1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (8) send_chip(1'b0);
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL split_sync: got busy=%b want 0", busy);
        end
        send_word(16'hFF00);
        step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_after_reset: got busy=%b want 1", busy);
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        chip_in    = 1'b0;
        chip_valid = 1'b0;
        byte_ready = 1'b1;
        test_reset();
        test_frame();
        test_code_err();
        test_len_zero();
        test_overflow();
        test_timeout();
        test_enable_drop();
        exp_q.delete();
        test_async_reset();
        exp_q.delete();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
